// File: rtl/mem_arbiter_2p_pkg.sv
// Shared types and helpers for the two-port memory arbiter.
package mem_arbiter_2p_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        CLEAR  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Winner of an arbitration round: 0 = port 0, 1 = port 1.
    function automatic logic pick_port(input logic rr_en, input logic req0,
                                       input logic req1, input logic last_gnt);
        if (req0 && req1 && rr_en)
            return ~last_gnt;
        return ~req0;
    endfunction

endpackage

// File: rtl/mem_arbiter_2p.sv
// Two-port req/ack arbiter and sequencer for a 256x8 sync-write / comb-read
// memory macro, with a whole-memory clear sequence.
module mem_arbiter_2p
    import mem_arbiter_2p_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter bit          RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire               dvdd,
    inout  wire               dgnd,
    input  logic              clr_req,
    output logic              clr_ack,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              mem_rstz
);

    // Supplies only pass through to the macro; nothing here consumes them.
    wire unused_supply = &{1'b0, dvdd, dgnd};

    state_t              state, state_nxt;
    logic                gnt_id, gnt_nxt;
    logic                last_gnt, last_gnt_nxt;
    logic                mem_en_nxt, mem_rw_nxt, mem_rstz_nxt;
    logic [ADDR_W-1:0]   mem_addr_nxt;
    logic [DATA_W-1:0]   mem_din_nxt;
    logic                ack0_nxt, ack1_nxt, clr_ack_nxt;
    logic [DATA_W-1:0]   rdata0_nxt, rdata1_nxt;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            gnt_id   <= 1'b0;
            last_gnt <= 1'b1;
            mem_en   <= 1'b0;
            mem_rw   <= RW_READ;
            mem_rstz <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            clr_ack  <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt != IDLE);
            gnt_id   <= gnt_nxt;
            last_gnt <= last_gnt_nxt;
            mem_en   <= mem_en_nxt;
            mem_rw   <= mem_rw_nxt;
            mem_rstz <= mem_rstz_nxt;
            mem_addr <= mem_addr_nxt;
            mem_din  <= mem_din_nxt;
            ack0     <= ack0_nxt;
            ack1     <= ack1_nxt;
            clr_ack  <= clr_ack_nxt;
            rdata0   <= rdata0_nxt;
            rdata1   <= rdata1_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt_id;
        last_gnt_nxt = last_gnt;
        mem_en_nxt   = mem_en;
        mem_rw_nxt   = mem_rw;
        mem_rstz_nxt = mem_rstz;
        mem_addr_nxt = mem_addr;
        mem_din_nxt  = mem_din;
        ack0_nxt     = ack0;
        ack1_nxt     = ack1;
        clr_ack_nxt  = clr_ack;
        rdata0_nxt   = rdata0;
        rdata1_nxt   = rdata1;

        case (state)
            IDLE: begin
                mem_en_nxt   = 1'b0;
                mem_rstz_nxt = 1'b1;
                if (clr_req) begin
                    mem_rstz_nxt = 1'b0;
                    state_nxt    = CLEAR;
                end else if (req0 || req1) begin
                    gnt_nxt    = pick_port(RR_EN, req0, req1, last_gnt);
                    mem_en_nxt = 1'b1;
                    if (gnt_nxt) begin
                        mem_rw_nxt   = we1 ? RW_WRITE : RW_READ;
                        mem_addr_nxt = addr1;
                        mem_din_nxt  = wdata1;
                    end else begin
                        mem_rw_nxt   = we0 ? RW_WRITE : RW_READ;
                        mem_addr_nxt = addr0;
                        mem_din_nxt  = wdata0;
                    end
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                // Macro read data is combinational; capture it at the closing edge.
                if (mem_rw == RW_READ) begin
                    if (gnt_id) rdata1_nxt = mem_dout;
                    else        rdata0_nxt = mem_dout;
                end
                mem_en_nxt   = 1'b0;
                mem_rw_nxt   = RW_READ;
                ack0_nxt     = ~gnt_id;
                ack1_nxt     = gnt_id;
                last_gnt_nxt = gnt_id;
                state_nxt    = DONE;
            end
            CLEAR: begin
                mem_rstz_nxt = 1'b1;
                clr_ack_nxt  = 1'b1;
                state_nxt    = DONE;
            end
            DONE: begin
                ack0_nxt    = 1'b0;
                ack1_nxt    = 1'b0;
                clr_ack_nxt = 1'b0;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Self-checking bench: a round-robin and a fixed-priority arbiter, each
// driving its own 256x8 memory model.
module tb_mem_arbiter_2p;

    logic clk;
    logic rst;
    wire  dvdd;
    wire  dgnd;
    assign dvdd = 1'b1;
    assign dgnd = 1'b0;

    // Index 0 = RR_EN=1 instance, index 1 = RR_EN=0 instance.
    logic [1:0] clr_req, clr_ack, req0, req1, we0, we1, ack0, ack1;
    logic [1:0] busy, mem_en, mem_rw, mem_rstz;
    logic [7:0] addr0 [2];
    logic [7:0] addr1 [2];
    logic [7:0] wdata0 [2];
    logic [7:0] wdata1 [2];
    logic [7:0] rdata0 [2];
    logic [7:0] rdata1 [2];
    logic [7:0] mem_addr [2];
    logic [7:0] mem_din [2];
    logic [7:0] mem_dout [2];
    logic [7:0] mem_r [256];
    logic [7:0] mem_f [256];

    int checks = 0;
    int errors = 0;

    mem_arbiter_2p #(.ADDR_W(8), .DATA_W(8), .RR_EN(1'b1)) u_dut_rr (
        .clk(clk), .rst(rst), .dvdd(dvdd), .dgnd(dgnd),
        .clr_req(clr_req[0]), .clr_ack(clr_ack[0]),
        .req0(req0[0]), .req1(req1[0]), .we0(we0[0]), .we1(we1[0]),
        .addr0(addr0[0]), .addr1(addr1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
        .ack0(ack0[0]), .ack1(ack1[0]), .rdata0(rdata0[0]), .rdata1(rdata1[0]),
        .busy(busy[0]), .mem_en(mem_en[0]), .mem_rw(mem_rw[0]),
        .mem_addr(mem_addr[0]), .mem_din(mem_din[0]), .mem_dout(mem_dout[0]),
        .mem_rstz(mem_rstz[0])
    );

    mem_arbiter_2p #(.ADDR_W(8), .DATA_W(8), .RR_EN(1'b0)) u_dut_fp (
        .clk(clk), .rst(rst), .dvdd(dvdd), .dgnd(dgnd),
        .clr_req(clr_req[1]), .clr_ack(clr_ack[1]),
        .req0(req0[1]), .req1(req1[1]), .we0(we0[1]), .we1(we1[1]),
        .addr0(addr0[1]), .addr1(addr1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
        .ack0(ack0[1]), .ack1(ack1[1]), .rdata0(rdata0[1]), .rdata1(rdata1[1]),
        .busy(busy[1]), .mem_en(mem_en[1]), .mem_rw(mem_rw[1]),
        .mem_addr(mem_addr[1]), .mem_din(mem_din[1]), .mem_dout(mem_dout[1]),
        .mem_rstz(mem_rstz[1])
    );

    // Memory macro models: synchronous clear wins over write; read is combinational.
    always @(posedge clk) begin
        if (!mem_rstz[0]) begin
            for (int i = 0; i < 256; i++) mem_r[i] <= 8'h00;
        end else if (mem_en[0] && mem_rw[0] == 1'b0) begin
            mem_r[mem_addr[0]] <= mem_din[0];
        end
    end

    always @(posedge clk) begin
        if (!mem_rstz[1]) begin
            for (int i = 0; i < 256; i++) mem_f[i] <= 8'h00;
        end else if (mem_en[1] && mem_rw[1] == 1'b0) begin
            mem_f[mem_addr[1]] <= mem_din[1];
        end
    end

    assign mem_dout[0] = mem_r[mem_addr[0]];
    assign mem_dout[1] = mem_f[mem_addr[1]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Full handshake on the round-robin instance; expects it idle on entry.
    task automatic access0(input bit port, input bit we, input logic [7:0] a, input logic [7:0] d);
        int n;
        bit got;
        bit other;
        n = 0; got = 1'b0; other = 1'b0;
        if (!port) begin
            we0[0] = we; addr0[0] = a; wdata0[0] = d; req0[0] = 1'b1;
        end else begin
            we1[0] = we; addr1[0] = a; wdata1[0] = d; req1[0] = 1'b1;
        end
        while (!got && n < 20) begin
            tick();
            n++;
            got   = port ? ack1[0] : ack0[0];
            other = other | (port ? ack0[0] : ack1[0]);
        end
        req0[0] = 1'b0;
        req1[0] = 1'b0;
        check("ack_latency", 32'(n), 32'd2);
        check("ack_other_port", 32'(other), 32'd0);
        tick();
    endtask

    typedef struct packed {
        bit       inst;
        bit       r0;
        bit       r1;
        bit [3:0] exp;   // {ack0, ack1, clr_ack, busy}
    } vec_t;

    vec_t vecs [25];

    initial begin
        int n;
        bit seen;

        vecs[0]  = '{1'b0, 1'b1, 1'b1, 4'b0001};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 4'b1001};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 4'b0000};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 4'b0001};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 4'b0101};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'b0001};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'b1001};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 4'b0000};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 4'b0001};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 4'b0101};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 4'b0000};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 4'b0001};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 4'b1001};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 4'b0001};
        vecs[16] = '{1'b1, 1'b1, 1'b1, 4'b1001};
        vecs[17] = '{1'b1, 1'b1, 1'b1, 4'b0000};
        vecs[18] = '{1'b1, 1'b1, 1'b1, 4'b0001};
        vecs[19] = '{1'b1, 1'b1, 1'b1, 4'b1001};
        vecs[20] = '{1'b1, 1'b1, 1'b1, 4'b0000};
        vecs[21] = '{1'b1, 1'b0, 1'b1, 4'b0001};
        vecs[22] = '{1'b1, 1'b0, 1'b1, 4'b0101};
        vecs[23] = '{1'b1, 1'b0, 1'b1, 4'b0000};
        vecs[24] = '{1'b1, 1'b0, 1'b0, 4'b0000};

        rst = 1'b1;
        clr_req = '0; req0 = '0; req1 = '0;
        we0 = 2'b11; we1 = 2'b11;
        for (int i = 0; i < 2; i++) begin
            addr0[i] = 8'h01; wdata0[i] = 8'h11;
            addr1[i] = 8'h02; wdata1[i] = 8'h22;
        end
        tick();
        tick();

        for (int i = 0; i < 2; i++) begin
            check("reset_ctrl", {busy[i], mem_en[i], mem_rw[i], mem_rstz[i]}, 4'b0010);
            check("reset_acks", {ack0[i], ack1[i], clr_ack[i]}, 3'b000);
            check("reset_bus", {mem_addr[i], mem_din[i], rdata0[i], rdata1[i]}, 32'h0);
        end
        rst = 1'b0;
        tick();

        // Arbitration: RR ties alternate, fixed priority always picks port 0.
        for (int i = 0; i < 25; i++) begin
            req0[vecs[i].inst] = vecs[i].r0;
            req1[vecs[i].inst] = vecs[i].r1;
            tick();
            check($sformatf("arb_vec%0d", i),
                  {ack0[vecs[i].inst], ack1[vecs[i].inst], clr_ack[vecs[i].inst], busy[vecs[i].inst]},
                  32'(vecs[i].exp));
        end
        check("rr_mem01", mem_r[1], 8'h11);
        check("rr_mem02", mem_r[2], 8'h22);
        check("fp_mem01", mem_f[1], 8'h11);
        check("fp_mem02", mem_f[2], 8'h22);
        check("writes_keep_rdata", {rdata0[0], rdata1[0], rdata0[1], rdata1[1]}, 32'h0);

        // Port 0 write then read back.
        access0(1'b0, 1'b1, 8'h10, 8'hA5);
        access0(1'b0, 1'b0, 8'h10, 8'h00);
        check("rd_rdata0", rdata0[0], 8'hA5);
        check("rd_rdata1_untouched", rdata1[0], 8'h00);

        // Clear beats a simultaneous port-1 read.
        access0(1'b0, 1'b1, 8'h80, 8'hFF);
        check("pre_clear_mem80", mem_r[8'h80], 8'hFF);
        clr_req[0] = 1'b1;
        we1[0] = 1'b0; addr1[0] = 8'h80; req1[0] = 1'b1;
        tick();
        check("clear_state", {busy[0], mem_en[0], mem_rstz[0]}, 3'b100);
        tick();
        check("clear_ack", {ack0[0], ack1[0], clr_ack[0]}, 3'b001);
        clr_req[0] = 1'b0;
        tick();
        check("clear_ack_end", {clr_ack[0], busy[0]}, 2'b00);
        check("clear_mem80", mem_r[8'h80], 8'h00);
        n = 0;
        while (!ack1[0] && n < 10) begin
            tick();
            n++;
        end
        req1[0] = 1'b0;
        check("post_clear_latency", 32'(n), 32'd2);
        check("post_clear_rdata1", rdata1[0], 8'h00);
        tick();

        // Port 1 drops req and changes operands after grant.
        access0(1'b0, 1'b1, 8'h00, 8'h7E);
        we1[0] = 1'b0; addr1[0] = 8'h00; req1[0] = 1'b1;
        tick();
        check("drop_grant", {busy[0], mem_en[0], mem_rw[0], mem_addr[0]}, {3'b111, 8'h00});
        req1[0] = 1'b0; we1[0] = 1'b1; addr1[0] = 8'h80; wdata1[0] = 8'h55;
        tick();
        check("drop_ack1", ack1[0], 1'b1);
        check("drop_rdata1", rdata1[0], 8'h7E);
        tick();
        tick();
        check("drop_no_reserve", {ack1[0], busy[0]}, 2'b00);
        check("drop_no_write", mem_r[8'h80], 8'h00);

        // Reset asserted mid-ACCESS of a write.
        we0[0] = 1'b1; addr0[0] = 8'h05; wdata0[0] = 8'h3C; req0[0] = 1'b1;
        tick();
        check("rst_pre_access", {busy[0], mem_en[0], mem_rw[0]}, 3'b110);
        #2 rst = 1'b1;
        #1;
        check("rst_async_ctrl", {busy[0], mem_en[0], mem_rw[0], mem_rstz[0]}, 4'b0010);
        check("rst_async_bus", {mem_addr[0], mem_din[0], rdata0[0], rdata1[0]}, 32'h0);
        req0[0] = 1'b0;
        seen = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seen = seen | ack0[0] | ack1[0];
            tick();
        end
        check("rst_no_ack", 32'(seen), 32'd0);
        check("rst_mem05", mem_r[5], 8'h00);
        access0(1'b0, 1'b0, 8'h05, 8'h00);
        check("rst_readback05", rdata0[0], 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
